// File: rtl/dnn_accel_pkg.sv
// +----------------------------------------------------------------------+
// | dnn_accel_pkg : shared feeder FSM encoding and control-bit indices   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package dnn_accel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } feeder_state_t;

  localparam int CTRL_ENB   = 0;
  localparam int CTRL_START = 1;

endpackage

`default_nettype wire

// File: rtl/feeder_fifo.sv
// +----------------------------------------------------------------------+
// | feeder_fifo : synchronous skid FIFO with occupancy count             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module feeder_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop & ~empty;
  // A pop frees a slot in the same cycle, so a full FIFO may still take a push.
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

`default_nettype wire

// File: rtl/line_data_feeder.sv
// +----------------------------------------------------------------------+
// | line_data_feeder : streams activation words from memory to the conv  |
// | engine through a credit-controlled skid FIFO.            Rev 1.0     |
// +----------------------------------------------------------------------+
`default_nettype none

module line_data_feeder
  import dnn_accel_pkg::*;
#(
  parameter int BIT_WIDTH   = 8,
  parameter int NUM_CHANNEL = 3,
  parameter int ADDR_WIDTH  = 16,
  parameter int REG_WIDTH   = 32,
  parameter int MEM_LATENCY = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_data_req,
  output logic [BIT_WIDTH*NUM_CHANNEL-1:0] o_data,
  output logic                             o_data_val,
  output logic [ADDR_WIDTH-1:0]            o_mem_addr,
  output logic                             o_mem_en,
  input  logic [BIT_WIDTH*NUM_CHANNEL-1:0] i_mem_data,
  input  logic [REG_WIDTH-1:0]             i_conf_ctrl,
  input  logic [REG_WIDTH-1:0]             i_conf_baseaddr,
  input  logic [REG_WIDTH-1:0]             i_conf_numword,
  output logic                             o_busy,
  output logic                             o_done
);

  localparam int DW  = BIT_WIDTH * NUM_CHANNEL;
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam int CRW = $clog2(FIFO_DEPTH + MEM_LATENCY + 1) + 1;

  feeder_state_t state, state_next;

  logic                   start_prev;
  logic                   start_edge;
  logic                   enb;
  logic [ADDR_WIDTH-1:0]  base_addr;
  logic [REG_WIDTH-1:0]   num_word;
  logic [REG_WIDTH-1:0]   issued;
  logic [REG_WIDTH-1:0]   sent;
  logic [MEM_LATENCY-1:0] inflight_sr;
  logic [CRW-1:0]         credit_used;
  logic [FCW-1:0]         fifo_count;
  logic                   fifo_empty;
  logic [DW-1:0]          fifo_dout;
  logic                   issue;
  logic                   pop;
  logic                   land;
  logic                   unused_fifo_full;
  logic                   unused_cfg;

  assign enb        = i_conf_ctrl[CTRL_ENB];
  assign start_edge = i_conf_ctrl[CTRL_START] & ~start_prev;
  assign pop        = i_data_req & enb & ~fifo_empty;
  assign land       = inflight_sr[MEM_LATENCY-1];
  assign unused_cfg = ^{i_conf_ctrl, i_conf_baseaddr};

  // Every read already strobed or still in the pipe holds a FIFO slot.
  always_comb begin
    credit_used = CRW'(fifo_count) + CRW'(o_mem_en);
    for (int i = 0; i < MEM_LATENCY; i++) begin
      credit_used = credit_used + CRW'(inflight_sr[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    o_busy     = 1'b1;
    o_done     = 1'b0;
    case (state)
      ST_IDLE: begin
        o_busy = 1'b0;
        if (start_edge) begin
          state_next = (i_conf_numword == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        issue = enb && (issued < num_word) && (credit_used < CRW'(FIFO_DEPTH));
        if (sent == num_word) state_next = ST_DONE;
      end
      ST_DONE: begin
        o_done     = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  generate
    if (MEM_LATENCY == 1) begin : g_sr_single
      always_ff @(posedge clk) begin
        if (rst) inflight_sr <= '0;
        else     inflight_sr <= o_mem_en;
      end
    end else begin : g_sr_multi
      always_ff @(posedge clk) begin
        if (rst) inflight_sr <= '0;
        else     inflight_sr <= {inflight_sr[MEM_LATENCY-2:0], o_mem_en};
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      start_prev <= 1'b0;
      base_addr  <= '0;
      num_word   <= '0;
      issued     <= '0;
      sent       <= '0;
      o_mem_en   <= 1'b0;
      o_mem_addr <= '0;
      o_data     <= '0;
      o_data_val <= 1'b0;
    end else begin
      start_prev <= i_conf_ctrl[CTRL_START];
      if (state == ST_IDLE && start_edge) begin
        base_addr <= i_conf_baseaddr[ADDR_WIDTH-1:0];
        num_word  <= i_conf_numword;
        issued    <= '0;
        sent      <= '0;
      end
      o_mem_en <= issue;
      if (issue) begin
        o_mem_addr <= base_addr + issued[ADDR_WIDTH-1:0];
        issued     <= issued + REG_WIDTH'(1);
      end
      o_data_val <= pop;
      if (pop) begin
        o_data <= fifo_dout;
        sent   <= sent + REG_WIDTH'(1);
      end
    end
  end

  feeder_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (land),
    .push_data (i_mem_data),
    .pop       (pop),
    .pop_data  (fifo_dout),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (unused_fifo_full)
  );

endmodule

`default_nettype wire
